// File: rtl/serial_collector_pkg.sv
// Shared defaults and FSM encoding for the serial-to-parallel collector.
// Included by the collector top and its bit index counter.
package serial_collector_pkg;

    localparam int WIDTH_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Index counter width; a 2-bit word still needs one index bit.
    function automatic int idx_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_collector_bit_index_counter.sv
// Bit position counter for the collector: counts sampled bits of the
// current word and flags the last position (WIDTH-1).
module bit_index_counter
    import serial_collector_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             tc
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;

    assign tc  = (idx_reg == LAST);
    assign idx = idx_reg;

    always_comb begin
        idx_next = idx_reg;
        if (clr) begin
            idx_next = '0;
        end else if (en) begin
            idx_next = tc ? '0 : idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            idx_reg <= '0;
        end else begin
            idx_reg <= idx_next;
        end
    end

endmodule

// File: rtl/serial_collector.sv
// LSB-first serial-to-parallel collector with a separate output holding
// register, valid/ready delivery, delivered-word counter and sticky overflow.
module serial_collector
    import serial_collector_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             r,
    input  logic             clr,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             busy
);

    localparam int IDX_W = idx_width(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] done_word;
    logic [WIDTH-1:0] word_reg, word_next;
    logic             word_valid_reg, word_valid_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;

    logic [IDX_W-1:0] idx;
    logic             tc;
    logic             sample;
    logic             complete;
    logic             handshake;

    // clr wins over din_valid, so a clearing edge never samples din.
    assign sample    = din_valid & ~clr;
    assign complete  = sample & tc;
    assign handshake = word_valid_reg & word_ready;

    bit_index_counter #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_bit_index (
        .clk (clk),
        .r   (r),
        .clr (clr),
        .en  (sample),
        .idx (idx),
        .tc  (tc)
    );

    // Per-bit steering: the completed word takes the final bit straight
    // from din, so it is ready on the same edge that samples it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic hit;
            assign hit           = (idx == IDX_W'(gi));
            assign done_word[gi] = hit ? din : acc_reg[gi];
            assign acc_next[gi]  = (clr || complete) ? 1'b0
                                 : (sample && hit)   ? din
                                 : acc_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = IDLE;
        end else if (sample) begin
            state_next = tc ? IDLE : COLLECT;
        end
    end

    always_comb begin
        word_next       = word_reg;
        word_valid_next = word_valid_reg;
        count_next      = count_reg;
        overflow_next   = overflow_reg;
        if (clr) begin
            word_next       = '0;
            word_valid_next = 1'b0;
            count_next      = '0;
            overflow_next   = 1'b0;
        end else begin
            if (handshake) begin
                count_next      = count_reg + 1'b1;
                word_valid_next = 1'b0;
            end
            // A word may only load into a free or just-emptied register.
            if (complete) begin
                if (!word_valid_reg || handshake) begin
                    word_next       = done_word;
                    word_valid_next = 1'b1;
                end else begin
                    overflow_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            word_reg       <= word_next;
            word_valid_reg <= word_valid_next;
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign word       = word_reg;
    assign word_valid = word_valid_reg;
    assign count      = count_reg;
    assign overflow   = overflow_reg;
    assign busy       = (state_reg == COLLECT);

endmodule

// File: tb/tb_serial_collector.sv
// Directed and random checks of serial_collector (WIDTH=4, CNT_W=5) against
// a bit-list / arithmetic reference model of word assembly and delivery.
module tb_serial_collector;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic       clr = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic [3:0] word;
    logic       word_valid;
    logic       word_ready = 1'b0;
    logic [4:0] count;
    logic       overflow;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_nbits = 0;
    int m_part  = 0;
    int m_word  = 0;
    bit m_valid = 0;
    int m_count = 0;
    bit m_ovf   = 0;

    serial_collector #(.WIDTH(4), .CNT_W(5)) dut (
        .clk        (clk),
        .r          (r),
        .clr        (clr),
        .din        (din),
        .din_valid  (din_valid),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .count      (count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".word"},       32'(word),       32'(m_word));
        chk({tag, ".word_valid"}, 32'(word_valid), 32'(m_valid));
        chk({tag, ".count"},      32'(count),      32'(m_count));
        chk({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
        chk({tag, ".busy"},       32'(busy),       32'(m_nbits != 0));
    endtask

    task automatic model_clear();
        m_nbits = 0; m_part = 0; m_word = 0; m_valid = 0; m_count = 0; m_ovf = 0;
    endtask

    // One clock edge of the model: bits accumulate as sum(d_k * 2^k).
    task automatic model_edge(input bit dv, input bit d, input bit rdy, input bit c);
        bit hs;
        bit done;
        int newword;
        if (c) begin
            model_clear();
            return;
        end
        hs = m_valid && rdy;
        done = 0;
        newword = 0;
        if (dv) begin
            m_part = m_part + (int'(d) << m_nbits);
            m_nbits++;
            if (m_nbits == 4) begin
                done = 1; newword = m_part; m_nbits = 0; m_part = 0;
            end
        end
        if (hs) begin
            m_count = (m_count + 1) % 32;
            m_valid = 0;
        end
        if (done) begin
            if (!m_valid) begin
                m_word = newword; m_valid = 1;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic step(input string tag, input bit dv, input bit d, input bit rdy, input bit c);
        din_valid = dv; din = d; word_ready = rdy; clr = c;
        model_edge(dv, d, rdy, c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic send_word(input string tag, input int value, input bit rdy_body, input bit rdy_last);
        for (int k = 0; k < 4; k++) begin
            step(tag, 1'b1, value[k], (k == 3) ? rdy_last : rdy_body, 1'b0);
        end
    endtask

    task automatic apply_reset(input string tag);
        r = 1'b0; din_valid = 1'b0; word_ready = 1'b0; clr = 1'b0;
        model_clear();
        #2;
        check_all(tag);
        @(negedge clk);
        r = 1'b1;
    endtask

    initial begin
        // Reset state
        apply_reset("reset");

        // Bits 0,0,1,1 with no consumer -> 4'hC held
        send_word("first", 32'hC, 1'b0, 1'b0);
        chk("first.literal_word", 32'(word), 32'hC);
        chk("first.literal_count", 32'(count), 32'd0);

        // Single ready pulse delivers it
        step("pulse", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pulse.literal_count", 32'(count), 32'd1);
        step("idle", 1'b0, 1'b0, 1'b1, 1'b0);

        // 32 words with ready always high: count wraps back to 0
        step("clr_a", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int w = 0; w < 32; w++) begin
            send_word("wrap", int'($urandom_range(0, 15)), 1'b1, 1'b1);
        end
        step("wrap_drain", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap.literal_count", 32'(count), 32'd0);

        // Overflow: 4'hC held, 4'h5 dropped
        step("clr_b", 1'b0, 1'b0, 1'b0, 1'b1);
        send_word("ovf_c", 32'hC, 1'b0, 1'b0);
        send_word("ovf_5", 32'h5, 1'b0, 1'b0);
        chk("ovf.literal_flag", 32'(overflow), 32'd1);
        chk("ovf.literal_word", 32'(word), 32'hC);
        step("ovf_clr", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("ovf_clr.literal_all", 32'({word, word_valid, count, overflow, busy}), 32'd0);

        // Back-to-back: A then 3, ready on the completion edge of 3
        send_word("b2b_a", 32'hA, 1'b0, 1'b0);
        chk("b2b.literal_a", 32'(word), 32'hA);
        send_word("b2b_3", 32'h3, 1'b0, 1'b1);
        chk("b2b.literal_3", 32'({word, word_valid, count}), 32'({4'h3, 1'b1, 5'd1}));

        // Reset after two bits; next word must not inherit them
        step("mid_a", 1'b1, 1'b1, 1'b0, 1'b0);
        step("mid_b", 1'b1, 1'b1, 1'b0, 1'b0);
        apply_reset("mid_reset");
        send_word("post_reset", 32'h1, 1'b0, 1'b0);
        chk("post_reset.literal_word", 32'(word), 32'h1);

        // Three idle cycles between every bit
        step("clr_c", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            bit [3:0] pat;
            pat = 4'h9;
            step("gap_bit", 1'b1, pat[k], 1'b0, 1'b0);
            if (k < 3) begin
                for (int g = 0; g < 3; g++) begin
                    step("gap_idle", 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                end
            end
        end
        chk("gap.literal_word", 32'(word), 32'h9);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 79) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_collector.md
SERIAL_COLLECTOR -- requirements
Module: serial_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: bits per word, legal range 2..8.
REQ-002 The block SHALL have parameter CNT_W, default 5: width of the delivered-word counter.
REQ-003 Port clk SHALL be input, width 1: single clock; all state changes on the rising edge.
REQ-004 Port r SHALL be input, width 1: reset, asynchronous, active-low.
REQ-005 Port clr SHALL be input, width 1: synchronous clear, active-high.
REQ-006 Port din SHALL be input, width 1: serial data bit, driven from the upstream shift register's Q[0].
REQ-007 Port din_valid SHALL be input, width 1: din is sampled on this cycle's edge.
REQ-008 Port word SHALL be output, width WIDTH: assembled parallel word.
REQ-009 Port word_valid SHALL be output, width 1: word holds an undelivered result.
REQ-010 Port word_ready SHALL be input, width 1: the consumer accepts word.
REQ-011 Port count SHALL be output, width CNT_W: number of words delivered, modulo 2^CNT_W.
REQ-012 Port overflow SHALL be output, width 1: sticky flag; a completed word was dropped.
REQ-013 Port busy SHALL be output, width 1: a partial word is in the accumulator.

Function
REQ-014 The collector FSM SHALL have two states:
- IDLE: bit index 0, no partial word.
- COLLECT: 1..WIDTH-1 bits held.
REQ-015 Bit ordering SHALL be LSB first: the k-th sampled bit, k=0..WIDTH-1, lands in accumulator bit k.
REQ-016 IDLE SHALL go to COLLECT on din_valid=1; COLLECT SHALL stay in COLLECT while the bit index is below WIDTH-1.
REQ-017 When bit WIDTH-1 is sampled, the FSM SHALL return to IDLE and the completed word SHALL be offered to the output register.
REQ-018 The output register SHALL be separate from the accumulator, so collection of the next word continues while a word is held.
REQ-019 Latency: word and word_valid=1 SHALL appear on the edge that samples the last bit, i.e. visible in the following cycle.
REQ-020 A handshake SHALL occur when word_valid=1 and word_ready=1 on an edge.
REQ-021 On a handshake, word_valid SHALL fall unless a new word completes on the same edge.
REQ-022 On a handshake, count SHALL increment by 1, wrapping from 2^CNT_W-1 to 0.
REQ-023 If a word completes on the same edge as a handshake, the new word SHALL load, word_valid SHALL stay 1, and count SHALL increment.
REQ-024 If a word completes while word_valid=1 and no handshake occurs, that word SHALL be dropped.
- The held word SHALL be unchanged.
- overflow SHALL set to 1.
- The FSM SHALL return to IDLE normally.
REQ-025 overflow SHALL stay set until r or clr.
REQ-026 While word_valid=1, word SHALL be stable.
REQ-027 word_ready while word_valid=0 SHALL have no effect.
REQ-028 din_valid=0 SHALL hold all collector state, with no timeout.
REQ-029 busy SHALL equal (state==COLLECT).
REQ-030 clr=1 SHALL have priority over all other inputs on that edge.
- FSM to IDLE, accumulator and word to 0, word_valid=0, count=0, overflow=0.
- din is ignored on that edge.

Reset
REQ-031 While r=0, outputs SHALL be: word=0, word_valid=0, count=0, overflow=0, busy=0, FSM=IDLE, accumulator=0.
REQ-032 Reset asserted mid-word SHALL discard the partial word and any held word.
REQ-033 After r rises, the first din_valid SHALL be treated as bit 0.

Structure
REQ-034 A shared package SHALL hold the WIDTH and CNT_W defaults and the FSM state encoding (IDLE=0, COLLECT=1).
REQ-035 One sub-module, bit_index_counter, SHALL be used: a ceil(log2(WIDTH))-bit counter with enable, clear and a terminal-count output at WIDTH-1.
REQ-036 Total RTL SHALL be 120-400 lines, built from flip-flops with asynchronous active-low reset.

Verification
REQ-037 Reset, then bits 0,0,1,1 with din_valid=1 and word_ready=0 -> word=4'b1100 and word_valid=1 after the 4th edge; count=0; busy=1 for 3 cycles.
REQ-038 Hold word_valid, then pulse word_ready=1 for one cycle -> word_valid=0 and count=1; repeat 32 words with immediate ready -> count wraps to 0.
REQ-039 Hold word=4'hC with word_ready=0, then stream 4 more bits forming 4'h5 -> overflow=1 and word stays 4'hC; then clr -> all outputs 0.
REQ-040 Back-to-back streaming, with word_ready=1 on the completion edge of the second word -> word goes 4'hA to 4'h3 with no word_valid gap; count=1.
REQ-041 r=0 after 2 bits of a word, then r=1 and 4 bits 1,0,0,0 -> word=4'h1; no stale bits.
REQ-042 Gaps of 3 idle cycles (din_valid=0) between every bit -> same word as the gap-free case; busy stays 1 through the gaps.
